// File: rtl/stopwatch_pkg.sv
// Shared constants, FSM state type and digit encoding for the stopwatch reporting blocks.
package stopwatch_pkg;

    localparam logic [7:0] CHR_COLON = 8'h3A;
    localparam logic [7:0] CHR_DOT   = 8'h2E;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;

    // Characters per record: "MM:SS.t" CR LF
    localparam int REC_LEN = 9;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // 0-9 -> '0'-'9'; non-BCD A-F -> 'A'-'F' so corrupted digits stay visible on the host
    function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 + {4'h0, d};
        end
        return 8'h37 + {4'h0, d};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer. A byte offered during the last cycle of a stop
// bit is accepted immediately, so characters can be chained without gaps.
//
// state | meaning
// IDLE  | line high, waiting for valid
// START | start bit (txd=0), one bit time
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (txd=1); may chain straight into START
module uart_tx_byte
    import stopwatch_pkg::*;
#(
    parameter int BDN = 208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int CW = $clog2(BDN);
    localparam logic [CW-1:0] CNT_LD = CW'(BDN - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          bit_end;

    assign bit_end = (cnt_q == '0);
    assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign txd     = txd_q;

    // State, baud down-counter, shift register and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end

    // Next-state: every bit reloads BDN-1 and ends when the counter reaches zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (valid) begin
                    state_d = START;
                    cnt_d   = CNT_LD;
                    sh_d    = data;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = CNT_LD;
                    bit_d   = 3'd0;
                    txd_d   = sh_q[0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_LD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (valid) begin
                        state_d = START;
                        cnt_d   = CNT_LD;
                        sh_d    = data;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/stopwatch_uart_report.sv
// Sends a "MM:SS.t" CR LF record of the stopwatch time over UART on request.
// Holds the time snapshot, character index, one-deep pending request and the character mux.
module stopwatch_uart_report
    import stopwatch_pkg::*;
#(
    parameter int FRQ  = 24000000,
    parameter int BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trg,
    input  logic [3:0] t_mil_2,
    input  logic [3:0] t_sec_0,
    input  logic [3:0] t_sec_1,
    input  logic [3:0] t_min_0,
    input  logic [3:0] t_min_1,
    output logic       uart_txd,
    output logic       busy
);

    localparam int BDN = FRQ / BAUD;
    localparam logic [3:0] LAST_IDX = 4'(REC_LEN - 1);

    logic [19:0] snap_q, snap_d;
    logic [3:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic        busy_q, busy_d;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        start_rec;

    // Snapshot layout: {min_1, min_0, sec_1, sec_0, mil_2}
    function automatic logic [7:0] char_at(input logic [3:0] idx, input logic [19:0] s);
        case (idx)
            4'd0:    return bcd2ascii(s[19:16]);
            4'd1:    return bcd2ascii(s[15:12]);
            4'd2:    return CHR_COLON;
            4'd3:    return bcd2ascii(s[11:8]);
            4'd4:    return bcd2ascii(s[7:4]);
            4'd5:    return CHR_DOT;
            4'd6:    return bcd2ascii(s[3:0]);
            4'd7:    return CHR_CR;
            default: return CHR_LF;
        endcase
    endfunction

    uart_tx_byte #(
        .BDN (BDN)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (tx_valid),
        .data  (tx_data),
        .ready (tx_ready),
        .txd   (uart_txd)
    );

    assign busy = busy_q;

    // Record-level state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
        end
    end

    // Feed the serializer one character per stop-bit end; restart directly when a request is waiting
    always_comb begin
        snap_d    = snap_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        tx_valid  = 1'b0;
        tx_data   = char_at(idx_q, snap_q);
        start_rec = 1'b0;

        if (busy_q && trg) begin
            pend_d = 1'b1;
        end

        if (!busy_q) begin
            start_rec = trg;
        end else if (tx_ready) begin
            if (idx_q < LAST_IDX) begin
                tx_valid = 1'b1;
                idx_d    = idx_q + 4'd1;
                tx_data  = char_at(idx_q + 4'd1, snap_q);
            end else if (pend_q || trg) begin
                start_rec = 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end

        // The first character comes from the live inputs since the snapshot lands this same edge
        if (start_rec) begin
            snap_d   = {t_min_1, t_min_0, t_sec_1, t_sec_0, t_mil_2};
            idx_d    = 4'd0;
            pend_d   = 1'b0;
            busy_d   = 1'b1;
            tx_valid = 1'b1;
            tx_data  = bcd2ascii(t_min_1);
        end
    end

endmodule

// File: tb/tb_stopwatch_uart_report.sv
// Directed bench: decodes the UART stream bit-by-bit and checks records, timing, pending and reset.
module tb_stopwatch_uart_report;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trg = 1'b0;
    logic [3:0] t_mil_2 = 4'd0;
    logic [3:0] t_sec_0 = 4'd0;
    logic [3:0] t_sec_1 = 4'd0;
    logic [3:0] t_min_0 = 4'd0;
    logic [3:0] t_min_1 = 4'd0;
    logic       uart_txd;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] rx_byte [9];
    logic [7:0] exp_b   [9];
    logic       rx_ok;
    int         rx_t0;

    stopwatch_uart_report #(
        .FRQ  (16),
        .BAUD (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trg      (trg),
        .t_mil_2  (t_mil_2),
        .t_sec_0  (t_sec_0),
        .t_sec_1  (t_sec_1),
        .t_min_0  (t_min_0),
        .t_min_1  (t_min_1),
        .uart_txd (uart_txd),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_digits(input logic [3:0] m1, m0, s1, s0, t);
        t_min_1 = m1; t_min_0 = m0; t_sec_1 = s1; t_sec_0 = s0; t_mil_2 = t;
    endtask

    task automatic set_exp(input logic [3:0] m1, m0, s1, s0, t);
        logic [3:0] d [5];
        d[0] = m1; d[1] = m0; d[2] = s1; d[3] = s0; d[4] = t;
        for (int i = 0; i < 5; i++) begin
            d[i] = d[i];
        end
        exp_b[0] = (m1 > 9) ? 8'h37 + {4'h0, m1} : 8'h30 + {4'h0, m1};
        exp_b[1] = (m0 > 9) ? 8'h37 + {4'h0, m0} : 8'h30 + {4'h0, m0};
        exp_b[2] = 8'h3A;
        exp_b[3] = (s1 > 9) ? 8'h37 + {4'h0, s1} : 8'h30 + {4'h0, s1};
        exp_b[4] = (s0 > 9) ? 8'h37 + {4'h0, s0} : 8'h30 + {4'h0, s0};
        exp_b[5] = 8'h2E;
        exp_b[6] = (t > 9) ? 8'h37 + {4'h0, t} : 8'h30 + {4'h0, t};
        exp_b[7] = 8'h0D;
        exp_b[8] = 8'h0A;
    endtask

    task automatic pulse_trg();
        @(negedge clk) trg = 1'b1;
        @(negedge clk) trg = 1'b0;
    endtask

    // Receiver: find a start bit within budget, then sample each bit mid-way (BDN=4 -> cycle 2)
    task automatic rx_record(input int budget);
        int n;
        n = 0;
        rx_ok = 1'b1;
        for (int c = 0; c < 9; c++) rx_byte[c] = 8'hFF;
        while (uart_txd !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (uart_txd !== 1'b0) begin
            rx_ok = 1'b0;
            return;
        end
        rx_t0 = cyc;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            for (int j = 0; j < 10; j++) begin
                if (!(c == 0 && j == 0)) repeat (4) @(negedge clk);
                if (j == 0) begin
                    if (uart_txd !== 1'b0) rx_ok = 1'b0;
                end else if (j == 9) begin
                    if (uart_txd !== 1'b1) rx_ok = 1'b0;
                end else begin
                    rx_byte[c][j-1] = uart_txd;
                end
            end
        end
    endtask

    // Returns cycles from rx_t0 until busy is seen low (bounded)
    task automatic wait_busy_low(output int dt);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        dt = (busy === 1'b0) ? cyc - rx_t0 : -1;
    endtask

    task automatic test_reset();
        logic bad;
        @(negedge clk);
        tests++;
        if (uart_txd !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: txd=%b busy=%b, required txd=1 busy=0", uart_txd, busy);
        end
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_idle: line left idle during 100 cycles (txd=%b busy=%b), required txd=1 busy=0", uart_txd, busy);
        end
    endtask

    task automatic test_basic_snapshot();
        int dt;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        set_exp(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        repeat (10) @(negedge clk);
        pulse_trg();
        tests++;
        if (uart_txd !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_start_edge: txd=%b busy=%b, required txd=0 busy=1", uart_txd, busy);
        end
        fork
            rx_record(1);
            begin
                repeat (90) @(negedge clk);
                set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
            end
        join
        tests++;
        if (rx_ok !== 1'b1) begin
            fails++;
            $display("FAIL basic_framing: ok=%b, required 1", rx_ok);
        end
        for (int c = 0; c < 9; c++) begin
            tests++;
            if (rx_byte[c] !== exp_b[c]) begin
                fails++;
                $display("FAIL basic_char%0d: got %h, required %h", c, rx_byte[c], exp_b[c]);
            end
        end
        wait_busy_low(dt);
        tests++;
        if (dt != 360) begin
            fails++;
            $display("FAIL basic_busy_len: busy fell after %0d cycles, required 360", dt);
        end
    endtask

    task automatic test_pending();
        logic [7:0] rec1 [9];
        logic       ok1;
        int         t1, dt;
        logic       bad;
        set_digits(4'd3, 4'd1, 4'd4, 4'd1, 4'd5);
        repeat (5) @(negedge clk);
        pulse_trg();
        fork
            begin
                rx_record(1);
                ok1 = rx_ok;
                t1 = rx_t0;
                for (int c = 0; c < 9; c++) rec1[c] = rx_byte[c];
                rx_record(10);
            end
            begin
                repeat (20) @(negedge clk);
                pulse_trg();
                repeat (30) @(negedge clk);
                pulse_trg();
                repeat (30) @(negedge clk);
                pulse_trg();
                repeat (100) @(negedge clk);
                set_digits(4'd2, 4'd6, 4'd5, 4'd3, 4'd8);
            end
        join
        set_exp(4'd3, 4'd1, 4'd4, 4'd1, 4'd5);
        tests++;
        if (ok1 !== 1'b1 || rec1[0] !== exp_b[0] || rec1[4] !== exp_b[4] || rec1[6] !== exp_b[6]) begin
            fails++;
            $display("FAIL pend_rec1: ok=%b chars %h %h %h, required 1 %h %h %h",
                     ok1, rec1[0], rec1[4], rec1[6], exp_b[0], exp_b[4], exp_b[6]);
        end
        set_exp(4'd2, 4'd6, 4'd5, 4'd3, 4'd8);
        for (int c = 0; c < 9; c++) begin
            tests++;
            if (rx_ok !== 1'b1 || rx_byte[c] !== exp_b[c]) begin
                fails++;
                $display("FAIL pend_rec2_char%0d: got %h ok=%b, required %h", c, rx_byte[c], rx_ok, exp_b[c]);
            end
        end
        tests++;
        if (rx_t0 - t1 != 360) begin
            fails++;
            $display("FAIL pend_gap: second start %0d cycles after first, required 360", rx_t0 - t1);
        end
        wait_busy_low(dt);
        tests++;
        if (dt != 360) begin
            fails++;
            $display("FAIL pend_busy_len: busy fell %0d cycles after second start, required 360", dt);
        end
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0 || uart_txd !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL pend_no_third: busy=%b txd=%b after two records, required idle", busy, uart_txd);
        end
    endtask

    task automatic test_back_to_back();
        int t1, dt;
        set_digits(4'd5, 4'd9, 4'd5, 4'd9, 4'hB);
        set_exp(4'd5, 4'd9, 4'd5, 4'd9, 4'hB);
        repeat (3) @(negedge clk);
        pulse_trg();
        rx_record(1);
        t1 = rx_t0;
        tests++;
        if (rx_ok !== 1'b1 || rx_byte[6] !== 8'h42) begin
            fails++;
            $display("FAIL b2b_hex_digit: char6=%h ok=%b, required 42", rx_byte[6], rx_ok);
        end
        // last stop bit ends at t1+360: raise trg during its final cycle
        while (cyc < t1 + 359) @(negedge clk);
        trg = 1'b1;
        @(negedge clk) trg = 1'b0;
        tests++;
        if (busy !== 1'b1 || uart_txd !== 1'b0 || cyc != t1 + 360) begin
            fails++;
            $display("FAIL b2b_restart: busy=%b txd=%b at +%0d, required busy=1 txd=0 at +360",
                     busy, uart_txd, cyc - t1);
        end
        rx_record(1);
        for (int c = 0; c < 9; c++) begin
            tests++;
            if (rx_ok !== 1'b1 || rx_byte[c] !== exp_b[c]) begin
                fails++;
                $display("FAIL b2b_rec2_char%0d: got %h ok=%b, required %h", c, rx_byte[c], rx_ok, exp_b[c]);
            end
        end
        wait_busy_low(dt);
        tests++;
        if (dt != 360) begin
            fails++;
            $display("FAIL b2b_busy_len: %0d, required 360", dt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   dt;
        logic bad;
        set_digits(4'd0, 4'd7, 4'd2, 4'd9, 4'd3);
        repeat (4) @(negedge clk);
        pulse_trg();
        repeat (50) @(negedge clk);
        pulse_trg();
        repeat (118) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (uart_txd !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: txd=%b busy=%b, required txd=1 busy=0", uart_txd, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL rst_pending_dropped: activity after reset, required idle");
        end
        set_digits(4'd4, 4'd2, 4'd0, 4'd1, 4'd6);
        set_exp(4'd4, 4'd2, 4'd0, 4'd1, 4'd6);
        pulse_trg();
        rx_record(1);
        for (int c = 0; c < 9; c++) begin
            tests++;
            if (rx_ok !== 1'b1 || rx_byte[c] !== exp_b[c]) begin
                fails++;
                $display("FAIL rst_clean_char%0d: got %h ok=%b, required %h", c, rx_byte[c], rx_ok, exp_b[c]);
            end
        end
        wait_busy_low(dt);
        tests++;
        if (dt != 360) begin
            fails++;
            $display("FAIL rst_clean_busy_len: %0d, required 360", dt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_snapshot();
        test_pending();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
